// File: rtl/bcd_scan_display.sv
// Four-digit BCD event counter with a multiplexed 7-segment scan driver and a 9999->0000 overflow pulse.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       ovf
);

    localparam int              CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_ZERO  = 7'b1111110;

    logic [3:0][3:0] dig;
    logic [3:0][3:0] dig_inc;
    logic            all_nines;
    logic            qual;
    logic [CW-1:0]   scan_cnt;
    logic [1:0]      idx;
    logic [3:0]      cur;
    logic            blank;
    logic [3:0]      an_nxt;
    logic [6:0]      seg_nxt;
    logic            carry;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    assign qual      = tick & en & ~clr;
    assign all_nines = (dig == 16'h9999);

    // Ripple the carry through all four digits within one cycle.
    always_comb begin
        dig_inc = dig;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (dig[i] == 4'd9) begin
                    dig_inc[i] = 4'd0;
                end else begin
                    dig_inc[i] = dig[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            dig <= '0;
            ovf <= 1'b0;
        end else begin
            ovf <= qual & all_nines;
            if (clr)
                dig <= '0;
            else if (qual)
                dig <= dig_inc;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign cur = dig[idx];

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    // A slot is blank when its digit and every digit above it are zero; d0 always shows.
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (dig[3:1] == 12'd0);
            2'd2:    blank = (dig[3:2] == 8'd0);
            2'd3:    blank = (dig[3] == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign an_nxt  = blank ? 4'b1111 : ~(4'b0001 << idx);
    assign seg_nxt = blank ? 7'b0000000 : seg_decode(cur);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= SEG_ZERO;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule
